mem_port_arbiter: RTL

//  Shares the CPU's single-port unified memory between instruction fetch (IF) and the load/store unit (LS).

---
 rtl/cpu_bus_pkg.sv | 27 ++
 rtl/mem_port_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared bus definitions for the CPU memory port: arbiter FSM encoding, owner tag and command payload.
package cpu_bus_pkg;

    localparam int unsigned BUS_AW = 32;
    localparam int unsigned BUS_DW = 32;
    localparam int unsigned BUS_SW = BUS_DW / 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_LS = 2'd2,
        ARB_RESP    = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    typedef struct packed {
        logic [BUS_AW-1:0] addr;
        logic              we;
        logic [BUS_SW-1:0] wstrb;
        logic [BUS_DW-1:0] wdata;
    } bus_cmd_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch and the load/store unit.
// LS has priority; IF wins the next conflict after STARVE_LIMIT consecutive losses.
// Every access is bounded by TIMEOUT cycles and answered with bus_err if memory stays silent.
module mem_port_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int unsigned AW           = BUS_AW,
    parameter int unsigned DW           = BUS_DW,
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [DW-1:0]   if_rdata,
    input  logic            ls_req,
    input  logic [AW-1:0]   ls_addr,
    input  logic            ls_we,
    input  logic [DW/8-1:0] ls_wstrb,
    input  logic [DW-1:0]   ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [DW-1:0]   ls_rdata,
    output logic            bus_err,
    output logic            mem_req,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [DW/8-1:0] mem_wstrb,
    output logic [DW-1:0]   mem_wdata,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

    arb_state_e      state_q, state_d;
    owner_e          owner_q, owner_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic            mem_req_q, mem_req_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            mem_we_q, mem_we_d;
    logic [SW-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            if_rvalid_q, if_rvalid_d;
    logic            ls_rvalid_q, ls_rvalid_d;
    logic [DW-1:0]   if_rdata_q, if_rdata_d;
    logic [DW-1:0]   ls_rdata_q, ls_rdata_d;
    logic            bus_err_q, bus_err_d;
    logic            if_gnt_c, ls_gnt_c;
    logic            win_if_c, win_ls_c;
    logic            done_c, timeout_c;
    logic [DW-1:0]   resp_data_c;

    // State and registered outputs; reset aborts any transaction silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWN_IF;
            starve_q    <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wstrb_q <= '0;
            mem_wdata_q <= '0;
            if_rvalid_q <= 1'b0;
            ls_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_rdata_q  <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            if_rvalid_q <= if_rvalid_d;
            ls_rvalid_q <= ls_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_rdata_q  <= ls_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    // Next-state: arbitration in IDLE, ack/timeout tracking in BUSY, one response cycle.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        starve_d    = starve_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = mem_we_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        if_rvalid_d = 1'b0;
        ls_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        bus_err_d   = 1'b0;
        if_gnt_c    = 1'b0;
        ls_gnt_c    = 1'b0;
        win_if_c    = 1'b0;
        win_ls_c    = 1'b0;
        done_c      = 1'b0;
        timeout_c   = 1'b0;
        resp_data_c = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (if_req && ls_req) begin
                    if (starve_q == CW'(STARVE_LIMIT)) begin
                        win_if_c = 1'b1;
                        starve_d = '0;
                    end else begin
                        win_ls_c = 1'b1;
                        starve_d = starve_q + CW'(1);
                    end
                end else if (if_req) begin
                    win_if_c = 1'b1;
                    starve_d = '0;
                end else begin
                    win_ls_c = ls_req;
                    starve_d = '0;
                end

                if (win_if_c) begin
                    if_gnt_c    = 1'b1;
                    owner_d     = OWN_IF;
                    state_d     = ARB_BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = if_addr;
                    mem_we_d    = 1'b0;
                    mem_wstrb_d = '0;
                    mem_wdata_d = '0;
                    tmo_d       = '0;
                end else if (win_ls_c) begin
                    ls_gnt_c    = 1'b1;
                    owner_d     = OWN_LS;
                    state_d     = ARB_BUSY_LS;
                    mem_req_d   = 1'b1;
                    mem_addr_d  = ls_addr;
                    mem_we_d    = ls_we;
                    mem_wstrb_d = ls_wstrb;
                    mem_wdata_d = ls_wdata;
                    tmo_d       = '0;
                end
            end

            ARB_BUSY_IF, ARB_BUSY_LS: begin
                if (mem_ack) begin
                    done_c      = 1'b1;
                    resp_data_c = mem_rdata;
                end else if (tmo_q == TW'(TIMEOUT)) begin
                    done_c    = 1'b1;
                    timeout_c = 1'b1;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end

                if (done_c) begin
                    mem_req_d = 1'b0;
                    state_d   = ARB_RESP;
                    bus_err_d = timeout_c;
                    if (owner_q == OWN_LS) begin
                        ls_rvalid_d = 1'b1;
                        ls_rdata_d  = resp_data_c;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = resp_data_c;
                    end
                end
            end

            ARB_RESP: begin
                tmo_d   = '0;
                state_d = ARB_IDLE;
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Grants are decided in the IDLE cycle the request is seen; held low during reset.
    assign if_gnt    = if_gnt_c & ~rst;
    assign ls_gnt    = ls_gnt_c & ~rst;
    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;
    assign bus_err   = bus_err_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;

endmodule
